ldtu_mode_sequencer: RTL and testbench
======================================

# ldtu_mode_sequencer

Orbit and mode sequencer for the LiTe-DTU encoder FSM. It keeps a bunch-crossing counter locked to the external BC0 marker and produces the one-cycle `Orbit` pulse the encoder uses to insert headers. It also sequences entry into and exit from fallback mode: it drains the encoder pipeline, then switches `fallback` only on an orbit boundary, so the encoder restarts cleanly from IDLE with a header.

## Interface
- `ORBIT_LEN`, 3564: bunch crossings per orbit; `bc_count` runs 0..ORBIT_LEN-1.
- `BC_W`, 12: `bc_count` width; ceil(log2(ORBIT_LEN)) must be ≤ BC_W.
- `DRAIN_CYCLES`, 4: minimum cycles spent in DRAIN/RESUME before a mode switch; must be ≥ 1.
- `CLK` in 1: LiTe-DTU clock; the block's only clock.
- `reset` in 1: asynchronous, active-low reset (0 = reset asserted).
- `enable` in 1: 1 = counter runs; 0 = counter holds and `bc0_sync` is ignored.
- `bc0_sync` in 1: one-cycle BC0 marker from the clock/control interface.
- `fallback_req` in 1: level from configuration; 1 requests fallback mode.
- `err_clr` in 1: clears `sync_err`.
- `Orbit` out 1: registered one-cycle orbit pulse to the encoder.
- `fallback` out 1: registered mode select to the encoder; 1 = fallback.
- `bc_count` out BC_W: current bunch-crossing count.
- `mode_state` out 2: NORMAL=00, DRAIN=01, FALLBACK=10, RESUME=11.
- `switching` out 1: 1 while in DRAIN or RESUME.
- `locked` out 1: 1 after the first accepted `bc0_sync`.
- `sync_err` out 1: sticky; set when `bc0_sync` arrives off the expected boundary.

## Operation
- **Reset values:** all outputs 0; `mode_state`=NORMAL; drain counter 0.
- **Next count (enable=1):**
  - if `bc0_sync`=1, `next_count`=0;
  - else if `bc_count`=ORBIT_LEN-1, `next_count`=0;
  - else `next_count`=`bc_count`+1.
  - With enable=0, `bc_count` holds and `next_count`=`bc_count`.
- **Lock:** `locked` is set by the first `bc0_sync` accepted with enable=1. It is cleared only by reset.
- **Orbit:** `Orbit` <= enable & (`locked` | `bc0_sync`) & (`next_count`==0). It is never high while unlocked, apart from the locking marker itself.
- **sync_err:** set when `bc0_sync`=1, enable=1, `locked`=1 and `bc_count`≠ORBIT_LEN-1. `err_clr` clears it; if set and clear occur in the same cycle, set wins. The counter still realigns to the marker.
- **Boundary condition:** `align` = !`locked` | (enable & `next_count`==0).
- **Drain counter:** loaded with DRAIN_CYCLES-1 on entry to DRAIN or RESUME. It decrements by one per cycle and saturates at 0. `expired` = (counter==0).
- **Mode FSM transitions:**
  - NORMAL (`fallback`=0): `fallback_req`=1 -> DRAIN.
  - DRAIN (`fallback`=0): `fallback_req`=0 -> NORMAL (abort); else `expired` & `align` -> FALLBACK; else stay.
  - FALLBACK (`fallback`=1): `fallback_req`=0 -> RESUME.
  - RESUME (`fallback`=1): `fallback_req`=1 -> FALLBACK (abort); else `expired` & `align` -> NORMAL; else stay.
- `fallback` is registered from the next state, so it changes in the same cycle that `Orbit` rises. The encoder therefore leaves IDLE on an Orbit cycle and emits a header first.
- While locked with enable=0, `align` is false and DRAIN/RESUME wait indefinitely.
- **Mid-operation reset:** all state returns to reset values immediately (asynchronous). `fallback` drops to 0 and `locked` must be re-acquired.

## Timing
- All outputs are registered; no combinational path runs from any input to any output.
- `bc0_sync` at edge t: `bc_count`=0 and `Orbit`=1 after edge t; `bc_count`=1 after edge t+1.
- Orbit period when locked and enabled: exactly ORBIT_LEN cycles, with `Orbit` high for 1 cycle.
- Fallback entry with `fallback_req` rising at edge t (locked): DRAIN after t. FALLBACK occurs at the first edge ≥ t+DRAIN_CYCLES at which the counter wraps.
- Fallback entry when unlocked: FALLBACK and `fallback`=1 exactly after edge t+DRAIN_CYCLES.
- Abort is taken on the edge after `fallback_req` changes, regardless of the drain counter.

## Test plan
Test configuration: ORBIT_LEN=16, DRAIN_CYCLES=4.
1. Reset, then enable=1 with no `bc0_sync` for 40 cycles -> `bc_count` wraps 15->0; `Orbit`=0, `locked`=0 throughout.
2. `bc0_sync` at `bc_count`=7 -> `bc_count`=0, `Orbit`=1, `locked`=1, `sync_err`=0. Then `Orbit` repeats every 16 cycles.
3. Locked; `bc0_sync` at `bc_count`=15 -> no `sync_err`. `bc0_sync` at `bc_count`=9 -> `sync_err`=1 and `bc_count`=0. `err_clr` together with a new off-boundary `bc0_sync` -> `sync_err` stays 1.
4. Locked; `fallback_req`=1 at `bc_count`=2 -> DRAIN (01), `switching`=1. `fallback`=1 and `mode_state`=10 in the cycle `Orbit`=1 (`bc_count`=0).
5. `fallback_req` 1->0 in FALLBACK -> RESUME. `fallback_req` back to 1 two cycles later -> FALLBACK with `fallback` never dropping.
6. Unlocked; `fallback_req`=1 -> `fallback`=1 exactly 4 cycles after DRAIN entry. Assert `reset`=0 mid-RESUME -> `fallback`=0, `mode_state`=00, `bc_count`=0 without waiting for a `CLK` edge.

Source files
------------

// File: rtl/ldtu_mode_sequencer_if.sv
// ldtu_mode_sequencer_if
//   Carries the control inputs and status outputs of the LiTe-DTU orbit/mode
//   sequencer. Clock and reset are kept as plain ports on the module.
//   master: drives enable, bc0_sync, fallback_req and err_clr; observes the status.
//   slave : the sequencer itself.
//   Status signals:
//     Orbit      - one-cycle orbit pulse
//     fallback   - encoder mode select
//     bc_count   - bunch-crossing count
//     mode_state - NORMAL/DRAIN/FALLBACK/RESUME
//     switching  - high during DRAIN or RESUME
//     locked     - BC0 has been seen
//     sync_err   - sticky misaligned-BC0 flag
interface ldtu_mode_sequencer_if #(
  parameter int BC_W = 12
);
  logic            enable;
  logic            bc0_sync;
  logic            fallback_req;
  logic            err_clr;
  logic            Orbit;
  logic            fallback;
  logic [BC_W-1:0] bc_count;
  logic [1:0]      mode_state;
  logic            switching;
  logic            locked;
  logic            sync_err;

  modport master (
    output enable, bc0_sync, fallback_req, err_clr,
    input  Orbit, fallback, bc_count, mode_state, switching, locked, sync_err
  );

  modport slave (
    input  enable, bc0_sync, fallback_req, err_clr,
    output Orbit, fallback, bc_count, mode_state, switching, locked, sync_err
  );
endinterface

// File: rtl/ldtu_mode_sequencer.sv
// ldtu_mode_sequencer
//   Keeps a bunch-crossing counter locked to BC0 and emits the Orbit pulse.
//   It sequences fallback entry and exit through a drain period. The switch
//   itself only happens on an orbit boundary, so the encoder restarts from
//   IDLE with a header.
//   Ports:
//     CLK   - the only clock
//     reset - asynchronous reset, active low
//     bus   - slave side of ldtu_mode_sequencer_if (controls in, status out)
module ldtu_mode_sequencer #(
  parameter int ORBIT_LEN    = 3564,
  parameter int BC_W         = 12,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  CLK,
  input  logic                  reset,
  ldtu_mode_sequencer_if.slave  bus
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]   DRN_LOAD = DW'(DRAIN_CYCLES - 1);
  localparam logic [BC_W-1:0] BC_LAST  = BC_W'(ORBIT_LEN - 1);

  // Encoding chosen so that bit1 is the fallback select and bit0 is "switching".
  typedef enum logic [1:0] {
    NORMAL   = 2'b00,
    DRAIN    = 2'b01,
    FALLBACK = 2'b10,
    RESUME   = 2'b11
  } mode_e;

  mode_e           state_q, state_d;
  logic [BC_W-1:0] bc_q, bc_d;
  logic [DW-1:0]   drn_q, drn_d;
  logic            locked_q, orbit_q, err_q;
  logic            wrap, at_zero, align, expired, err_set;

  assign wrap    = (bc_q == BC_LAST);
  assign expired = (drn_q == '0);
  assign err_set = bus.bc0_sync & bus.enable & locked_q & ~wrap;

  // Next count. BC0 realigns the counter even when it arrives off-boundary.
  always_comb begin
    bc_d = bc_q;
    if (bus.enable) begin
      if (bus.bc0_sync || wrap) bc_d = '0;
      else                      bc_d = bc_q + 1'b1;
    end
  end

  assign at_zero = (bc_d == '0);
  // Unlocked: no orbit exists yet, so any cycle counts as a boundary.
  assign align   = ~locked_q | (bus.enable & at_zero);

  always_comb begin
    state_d = state_q;
    drn_d   = expired ? drn_q : drn_q - 1'b1;
    unique case (state_q)
      NORMAL:   if (bus.fallback_req) state_d = DRAIN;
      DRAIN:    if (!bus.fallback_req)   state_d = NORMAL;
                else if (expired && align) state_d = FALLBACK;
      FALLBACK: if (!bus.fallback_req) state_d = RESUME;
      RESUME:   if (bus.fallback_req)    state_d = FALLBACK;
                else if (expired && align) state_d = NORMAL;
      default:  state_d = NORMAL;
    endcase
    // Reload whenever a drain-type state is freshly entered, including after an abort.
    if ((state_d == DRAIN && state_q != DRAIN) || (state_d == RESUME && state_q != RESUME))
      drn_d = DRN_LOAD;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q  <= NORMAL;
      bc_q     <= '0;
      drn_q    <= '0;
      locked_q <= 1'b0;
      orbit_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bc_q     <= bc_d;
      drn_q    <= drn_d;
      locked_q <= locked_q | (bus.enable & bus.bc0_sync);
      orbit_q  <= bus.enable & (locked_q | bus.bc0_sync) & at_zero;
      // A set request takes priority over a clear in the same cycle.
      err_q    <= err_set | (err_q & ~bus.err_clr);
    end
  end

  assign bus.Orbit      = orbit_q;
  assign bus.bc_count   = bc_q;
  assign bus.mode_state = state_q;
  // These are decoded from the state register. Because the state register is
  // loaded from the next state, fallback changes on the same edge that raises Orbit.
  assign bus.fallback   = state_q[1];
  assign bus.switching  = state_q[0];
  assign bus.locked     = locked_q;
  assign bus.sync_err   = err_q;

endmodule

// File: tb/tb_ldtu_mode_sequencer.sv
// tb_ldtu_mode_sequencer
//   Runs directed scenarios followed by a randomized phase. The DUT is checked
//   against a cycle-level reference model that works from mode names, modulo
//   counting and elapsed time in each state.
module tb_ldtu_mode_sequencer;
  localparam int L   = 16;
  localparam int BCW = 5;
  localparam int DC  = 4;
  localparam int MN = 0, MD = 1, MF = 2, MR = 3;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  ldtu_mode_sequencer_if #(.BC_W(BCW)) bus();

  ldtu_mode_sequencer #(.ORBIT_LEN(L), .BC_W(BCW), .DRAIN_CYCLES(DC)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_cnt, m_since, m_mode;
  bit m_locked, m_orbit, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_since = 0; m_mode = MN;
    m_locked = 0; m_orbit = 0; m_err = 0;
  endtask

  task automatic model_update();
    bit en, b0, req, clr, al, ex;
    int nc, nm;
    en = bus.enable; b0 = bus.bc0_sync; req = bus.fallback_req; clr = bus.err_clr;
    nc = !en ? m_cnt : (b0 ? 0 : (m_cnt + 1) % L);
    al = !m_locked || (en && nc == 0);
    ex = (m_since >= DC - 1);
    nm = m_mode;
    case (m_mode)
      MN: if (req) nm = MD;
      MD: if (!req) nm = MN; else if (ex && al) nm = MF;
      MF: if (!req) nm = MR;
      MR: if (req) nm = MF; else if (ex && al) nm = MN;
      default: nm = MN;
    endcase
    if ((nm == MD || nm == MR) && nm != m_mode) m_since = 0;
    else if (m_since < 1000) m_since++;
    m_orbit = en && (m_locked || b0) && nc == 0;
    if (b0 && en && m_locked && m_cnt != L - 1) m_err = 1;
    else if (clr) m_err = 0;
    if (en && b0) m_locked = 1;
    m_cnt = nc;
    m_mode = nm;
  endtask

  task automatic check_all();
    chk("bc_count",   bus.bc_count,   m_cnt);
    chk("Orbit",      bus.Orbit,      m_orbit);
    chk("locked",     bus.locked,     m_locked);
    chk("sync_err",   bus.sync_err,   m_err);
    chk("mode_state", bus.mode_state, m_mode);
    chk("fallback",   bus.fallback,   (m_mode == MF || m_mode == MR));
    chk("switching",  bus.switching,  (m_mode == MD || m_mode == MR));
  endtask

  task automatic step();
    @(posedge CLK);
    model_update();
    #1;
    check_all();
  endtask

  // Step until the DUT counter reaches target, with a bounded number of cycles.
  task automatic run_to(input int target);
    for (int i = 0; i < 2 * L && m_cnt != target; i++) step();
    chk("run_to", bus.bc_count, target);
  endtask

  // Assert reset between edges and check that the outputs clear without a clock edge.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge CLK);
    reset = 1'b1;
  endtask

  initial begin
    int orbits, guard;
    reset = 1'b0;
    bus.enable = 0; bus.bc0_sync = 0; bus.fallback_req = 0; bus.err_clr = 0;
    model_reset();
    #12;
    check_all();
    chk("rst_mode", bus.mode_state, 2'b00);
    @(negedge CLK);
    reset = 1'b1;

    // 1: free-running while unlocked, no Orbit
    bus.enable = 1;
    orbits = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.Orbit) orbits++;
    end
    chk("unlocked_orbits", orbits, 0);

    // 2: lock on an off-boundary marker, then the orbit period
    run_to(7);
    bus.bc0_sync = 1; step(); bus.bc0_sync = 0;
    chk("lock_cnt", bus.bc_count, 0);
    chk("lock_orbit", bus.Orbit, 1);
    chk("lock_locked", bus.locked, 1);
    chk("lock_err", bus.sync_err, 0);
    orbits = 0;
    for (int i = 0; i < 2 * L; i++) begin
      step();
      if (bus.Orbit) orbits++;
    end
    chk("orbit_period", orbits, 2);

    // 3: sync_err behaviour
    run_to(15);
    bus.bc0_sync = 1; step(); bus.bc0_sync = 0;
    chk("err_ok_bc0", bus.sync_err, 0);
    run_to(9);
    bus.bc0_sync = 1; step(); bus.bc0_sync = 0;
    chk("err_set", bus.sync_err, 1);
    chk("err_realign", bus.bc_count, 0);
    run_to(4);
    bus.bc0_sync = 1; bus.err_clr = 1; step(); bus.bc0_sync = 0;
    chk("err_set_wins", bus.sync_err, 1);
    step(); bus.err_clr = 0;
    chk("err_clr", bus.sync_err, 0);

    // 4: locked fallback entry waits for the orbit boundary
    run_to(2);
    bus.fallback_req = 1; step();
    chk("drain_mode", bus.mode_state, 2'b01);
    chk("drain_sw", bus.switching, 1);
    guard = 0;
    while (!bus.Orbit && guard < 3 * L) begin step(); guard++; end
    chk("fb_orbit_seen", bus.Orbit, 1);
    chk("fb_at_orbit", bus.fallback, 1);
    chk("fb_mode", bus.mode_state, 2'b10);
    chk("fb_cnt", bus.bc_count, 0);

    // 5: resume followed by an abort back to fallback
    step();
    bus.fallback_req = 0; step();
    chk("resume_mode", bus.mode_state, 2'b11);
    step();
    bus.fallback_req = 1; step();
    chk("abort_mode", bus.mode_state, 2'b10);
    chk("abort_fb", bus.fallback, 1);

    // Randomized phase
    for (int i = 0; i < 1500; i++) begin
      bus.enable   = ($urandom_range(9) != 0);
      bus.bc0_sync = (m_cnt == L - 1) ? ($urandom_range(3) == 0) : ($urandom_range(59) == 0);
      if ($urandom_range(11) == 0) bus.fallback_req = ~bus.fallback_req;
      bus.err_clr  = ($urandom_range(7) == 0);
      step();
      if ($urandom_range(399) == 0) async_reset();
    end
    bus.bc0_sync = 0; bus.err_clr = 0; bus.fallback_req = 0;

    // 6: unlocked fallback entry timing, then reset in the middle of RESUME
    async_reset();
    bus.enable = 1;
    step(); step();
    bus.fallback_req = 1; step();
    chk("u_drain", bus.mode_state, 2'b01);
    for (int i = 0; i < DC - 1; i++) begin
      step();
      chk("u_not_yet", bus.fallback, 0);
    end
    step();
    chk("u_fb_exact", bus.fallback, 1);
    chk("u_fb_mode", bus.mode_state, 2'b10);
    bus.fallback_req = 0; step(); step();
    chk("u_resume", bus.mode_state, 2'b11);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_fb", bus.fallback, 0);
    chk("mid_rst_mode", bus.mode_state, 2'b00);
    chk("mid_rst_cnt", bus.bc_count, 0);
    chk("mid_rst_lock", bus.locked, 0);
    model_reset();
    @(negedge CLK);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
